// File: rtl/ball_ctrl.sv
// ---------------------------------------------------------------------------
// ball_ctrl
//
// Frame-rate ball motion controller for the pong datapath. Once per frame
// tick it advances the ball, bounces it off the top/bottom walls and the two
// paddles, detects misses, keeps both scores and re-serves from the centre.
//
// Sprite records are carried as packed vectors laid out as
//   {x_pos[X_POS_W], y_pos[Y_POS_W], right[X_POS_W], bottom[Y_POS_W]}
// (x_pos in the most significant bits, bottom in the least significant).
//
// Ports
//   clk_i           in   system clock
//   rst_i           in   synchronous, active-high reset
//   frame_tick_i    in   one-cycle pulse per frame, the only update strobe
//   player_i        in   left paddle sprite record
//   enemy_i         in   right paddle sprite record
//   ball_o          out  registered ball sprite record
//   score_player_o  out  player points, saturating at 15
//   score_enemy_o   out  enemy points, saturating at 15
//   point_o         out  high for the single cycle spent in SCORED
// ---------------------------------------------------------------------------
module ball_ctrl #(
    parameter int X_POS_W          = 10,
    parameter int Y_POS_W          = 10,
    parameter int SCREEN_H_RES     = 640,
    parameter int SCREEN_V_RES     = 480,
    parameter int BALL_SIDE        = 10,
    parameter int SCREEN_BORDER    = 10,
    parameter int PADDLE_HEIGHT    = 50,
    parameter int SPEED_W          = 5,
    parameter int DEFLECT_SPEED_X  = 4,
    parameter int DEFLECT_SPEED_Y  = 1,
    parameter int SIDE_HIT_SPEED_Y = 5,
    parameter int SERVE_DELAY      = 60
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               frame_tick_i,
    input  logic [2*X_POS_W+2*Y_POS_W-1:0]     player_i,
    input  logic [2*X_POS_W+2*Y_POS_W-1:0]     enemy_i,
    output logic [2*X_POS_W+2*Y_POS_W-1:0]     ball_o,
    output logic [3:0]                         score_player_o,
    output logic [3:0]                         score_enemy_o,
    output logic                               point_o
);

    localparam int SPRITE_W = 2*X_POS_W + 2*Y_POS_W;
    // One extra bit on every compare so sums near the screen edge never wrap.
    localparam int XW    = X_POS_W + 1;
    localparam int YW    = Y_POS_W + 1;
    localparam int VY_W  = SPEED_W - 1;
    localparam int CNT_W = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY + 1) : 1;

    localparam logic [1:0] ST_SERVE  = 2'd0;
    localparam logic [1:0] ST_MOVE   = 2'd1;
    localparam logic [1:0] ST_SCORED = 2'd2;

    // Wide constants for comparisons
    localparam logic [XW-1:0] C_BALL_X    = XW'(BALL_SIDE);
    localparam logic [XW-1:0] C_DX_X      = XW'(DEFLECT_SPEED_X);
    localparam logic [XW-1:0] C_H_RES     = XW'(SCREEN_H_RES);
    localparam logic [YW-1:0] C_BALL_Y    = YW'(BALL_SIDE);
    localparam logic [YW-1:0] C_HALF_BALL = YW'(BALL_SIDE / 2);
    localparam logic [YW-1:0] C_HALF_PAD  = YW'(PADDLE_HEIGHT / 2);
    localparam logic [YW-1:0] C_QUART_PAD = YW'(PADDLE_HEIGHT / 4);
    localparam logic [YW-1:0] C_BORDER    = YW'(SCREEN_BORDER);
    localparam logic [YW-1:0] C_Y_LIMIT   = YW'(SCREEN_V_RES - SCREEN_BORDER);

    // Narrow constants for position updates
    localparam logic [X_POS_W-1:0] C_CX       = X_POS_W'(SCREEN_H_RES/2 - BALL_SIDE/2);
    localparam logic [Y_POS_W-1:0] C_CY       = Y_POS_W'(SCREEN_V_RES/2 - BALL_SIDE/2);
    localparam logic [X_POS_W-1:0] C_DX_N     = X_POS_W'(DEFLECT_SPEED_X);
    localparam logic [X_POS_W-1:0] C_BALL_XN  = X_POS_W'(BALL_SIDE);
    localparam logic [X_POS_W-1:0] C_EXT_XN   = X_POS_W'(BALL_SIDE - 1);
    localparam logic [Y_POS_W-1:0] C_EXT_YN   = Y_POS_W'(BALL_SIDE - 1);
    localparam logic [Y_POS_W-1:0] C_BORDER_N = Y_POS_W'(SCREEN_BORDER);
    localparam logic [Y_POS_W-1:0] C_FLOOR_N  = Y_POS_W'(SCREEN_V_RES - SCREEN_BORDER - BALL_SIDE);

    localparam logic [VY_W-1:0]  C_VY_CENTRE = VY_W'(DEFLECT_SPEED_Y);
    localparam logic [VY_W-1:0]  C_VY_EDGE   = VY_W'(SIDE_HIT_SPEED_Y);
    localparam logic [CNT_W-1:0] C_SERVE_END = CNT_W'(SERVE_DELAY - 1);

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [X_POS_W-1:0] r_x;
    logic [Y_POS_W-1:0] r_y;
    logic [X_POS_W-1:0] r_right;
    logic [Y_POS_W-1:0] r_bottom;
    logic               r_dir_x;      // 1 = moving right
    logic               r_dir_y;      // 1 = moving up
    logic [VY_W-1:0]    r_vy;
    logic               r_scorer;     // 1 = player took the last point
    logic [3:0]         r_score_p;
    logic [3:0]         r_score_e;

    // ------------------------------------------------------------------
    // Ball geometry, widened
    // ------------------------------------------------------------------
    logic [XW-1:0] w_x;
    logic [YW-1:0] w_y;
    logic [XW-1:0] w_right;
    logic [YW-1:0] w_bottom;
    logic [YW-1:0] w_ball_cy;

    assign w_x       = {1'b0, r_x};
    assign w_y       = {1'b0, r_y};
    assign w_right   = w_x + C_BALL_X - XW'(1);
    assign w_bottom  = w_y + C_BALL_Y - YW'(1);
    assign w_ball_cy = w_y + C_HALF_BALL;

    // ------------------------------------------------------------------
    // Per-paddle decode: index 0 is the left (player) paddle, 1 the right
    // (enemy) paddle. Each slot yields a hit flag plus zoning results.
    // ------------------------------------------------------------------
    logic [SPRITE_W-1:0] w_pad_rec [2];
    logic [XW-1:0]       w_pad_x   [2];
    logic [YW-1:0]       w_pad_y   [2];
    logic [XW-1:0]       w_pad_r   [2];
    logic [YW-1:0]       w_pad_b   [2];
    logic                w_hit     [2];
    logic                w_near    [2];
    logic                w_above   [2];

    assign w_pad_rec[0] = player_i;
    assign w_pad_rec[1] = enemy_i;

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_pad
        logic [YW-1:0] w_pc;
        logic          w_overlap_y;

        assign w_pad_x[gi] = {1'b0, w_pad_rec[gi][SPRITE_W-1 -: X_POS_W]};
        assign w_pad_y[gi] = {1'b0, w_pad_rec[gi][X_POS_W+2*Y_POS_W-1 -: Y_POS_W]};
        assign w_pad_r[gi] = {1'b0, w_pad_rec[gi][X_POS_W+Y_POS_W-1 -: X_POS_W]};
        assign w_pad_b[gi] = {1'b0, w_pad_rec[gi][Y_POS_W-1:0]};

        assign w_pc        = w_pad_y[gi] + C_HALF_PAD;
        assign w_above[gi] = (w_ball_cy < w_pc);
        // Absolute distance between centres, taken in whichever order is non-negative.
        assign w_near[gi]  = w_above[gi] ? ((w_pc - w_ball_cy) <= C_QUART_PAD)
                                         : ((w_ball_cy - w_pc) <= C_QUART_PAD);
        assign w_overlap_y = (w_bottom >= w_pad_y[gi]) && (w_y <= w_pad_b[gi]);

        if (gi == 0) begin : g_left
            // A hit window one step wide in front of the paddle face catches the
            // ball before its next move would carry it through.
            assign w_hit[gi] = !r_dir_x
                             && (w_x <= w_pad_r[gi] + C_DX_X)
                             && (w_right >= w_pad_x[gi])
                             && w_overlap_y;
        end else begin : g_right
            assign w_hit[gi] = r_dir_x
                             && (w_right + C_DX_X >= w_pad_x[gi])
                             && (w_x <= w_pad_r[gi])
                             && w_overlap_y;
        end
    end

    // Landing positions after a paddle deflection
    logic [X_POS_W-1:0] w_left_land;
    logic [X_POS_W-1:0] w_right_land;

    assign w_left_land  = player_i[X_POS_W+Y_POS_W-1 -: X_POS_W] + X_POS_W'(1);
    assign w_right_land = enemy_i[SPRITE_W-1 -: X_POS_W] - C_BALL_XN;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic [1:0]         w_state_next;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [X_POS_W-1:0] w_x_next;
    logic [Y_POS_W-1:0] w_y_next;
    logic               w_dir_x_next;
    logic               w_dir_y_next;
    logic [VY_W-1:0]    w_vy_next;
    logic               w_scorer_next;
    logic [3:0]         w_score_p_next;
    logic [3:0]         w_score_e_next;
    logic [VY_W-1:0]    w_vy_eff;
    logic               w_dir_y_eff;
    logic [YW-1:0]      w_vy_ext;

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_x_next       = r_x;
        w_y_next       = r_y;
        w_dir_x_next   = r_dir_x;
        w_dir_y_next   = r_dir_y;
        w_vy_next      = r_vy;
        w_scorer_next  = r_scorer;
        w_score_p_next = r_score_p;
        w_score_e_next = r_score_e;
        w_vy_eff       = r_vy;
        w_dir_y_eff    = r_dir_y;
        w_vy_ext       = {{(YW-VY_W){1'b0}}, r_vy};

        case (r_state)
            ST_SERVE: begin
                if (frame_tick_i) begin
                    if (r_cnt == C_SERVE_END) begin
                        w_cnt_next   = '0;
                        w_state_next = ST_MOVE;
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end
            end

            ST_MOVE: begin
                if (frame_tick_i) begin
                    // x axis: paddle hits win over misses
                    if (w_hit[0]) begin
                        w_x_next     = w_left_land;
                        w_dir_x_next = 1'b1;
                        w_vy_eff     = w_near[0] ? C_VY_CENTRE : C_VY_EDGE;
                        w_dir_y_eff  = w_above[0];
                    end else if (w_hit[1]) begin
                        w_x_next     = w_right_land;
                        w_dir_x_next = 1'b0;
                        w_vy_eff     = w_near[1] ? C_VY_CENTRE : C_VY_EDGE;
                        w_dir_y_eff  = w_above[1];
                    end else if (!r_dir_x && (w_x < C_DX_X)) begin
                        w_state_next  = ST_SCORED;
                        w_scorer_next = 1'b0;
                    end else if (r_dir_x && (w_x + C_BALL_X + C_DX_X > C_H_RES)) begin
                        w_state_next  = ST_SCORED;
                        w_scorer_next = 1'b1;
                    end else if (r_dir_x) begin
                        w_x_next = r_x + C_DX_N;
                    end else begin
                        w_x_next = r_x - C_DX_N;
                    end

                    // y axis: the wall clamp sees any speed/direction just set by zoning
                    w_vy_ext     = {{(YW-VY_W){1'b0}}, w_vy_eff};
                    w_vy_next    = w_vy_eff;
                    w_dir_y_next = w_dir_y_eff;
                    if (w_dir_y_eff) begin
                        if (w_y < C_BORDER + w_vy_ext) begin
                            w_y_next     = C_BORDER_N;
                            w_dir_y_next = 1'b0;
                        end else begin
                            w_y_next = r_y - Y_POS_W'(w_vy_eff);
                        end
                    end else begin
                        if (w_y + C_BALL_Y + w_vy_ext > C_Y_LIMIT) begin
                            w_y_next     = C_FLOOR_N;
                            w_dir_y_next = 1'b1;
                        end else begin
                            w_y_next = r_y + Y_POS_W'(w_vy_eff);
                        end
                    end
                end
            end

            ST_SCORED: begin
                // Ticks are not looked at here; this state always lasts one clock.
                if (r_scorer) begin
                    if (r_score_p != 4'd15) w_score_p_next = r_score_p + 4'd1;
                    w_dir_x_next = 1'b1;
                end else begin
                    if (r_score_e != 4'd15) w_score_e_next = r_score_e + 4'd1;
                    w_dir_x_next = 1'b0;
                end
                w_x_next     = C_CX;
                w_y_next     = C_CY;
                w_vy_next    = C_VY_CENTRE;
                w_state_next = ST_SERVE;
            end

            default: begin
                w_state_next = ST_SERVE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_SERVE;
            r_cnt     <= '0;
            r_x       <= C_CX;
            r_y       <= C_CY;
            r_right   <= C_CX + C_EXT_XN;
            r_bottom  <= C_CY + C_EXT_YN;
            r_dir_x   <= 1'b0;
            r_dir_y   <= 1'b0;
            r_vy      <= C_VY_CENTRE;
            r_scorer  <= 1'b0;
            r_score_p <= 4'd0;
            r_score_e <= 4'd0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_x       <= w_x_next;
            r_y       <= w_y_next;
            r_right   <= w_x_next + C_EXT_XN;
            r_bottom  <= w_y_next + C_EXT_YN;
            r_dir_x   <= w_dir_x_next;
            r_dir_y   <= w_dir_y_next;
            r_vy      <= w_vy_next;
            r_scorer  <= w_scorer_next;
            r_score_p <= w_score_p_next;
            r_score_e <= w_score_e_next;
        end
    end

    assign ball_o         = {r_x, r_y, r_right, r_bottom};
    assign score_player_o = r_score_p;
    assign score_enemy_o  = r_score_e;
    assign point_o        = (r_state == ST_SCORED);

endmodule

// File: tb/tb_ball_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ball_ctrl
//
// Randomised game play against a behavioural model of the ball rules. The
// stimulus process drives ticks/paddles, advances the model and queues the
// expected outputs; a monitor process compares the DUT one cycle after every
// tick and after every point pulse.
// ---------------------------------------------------------------------------
module tb_ball_ctrl;

    localparam int SD     = 2;
    localparam int B      = 10;
    localparam int H      = 640;
    localparam int V      = 480;
    localparam int BORDER = 10;
    localparam int PH     = 50;
    localparam int DX     = 4;
    localparam int DY     = 1;
    localparam int SY     = 5;
    localparam int CX     = H/2 - B/2;
    localparam int CY     = V/2 - B/2;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        frame_tick_i = 1'b0;
    logic [39:0] player_i = '0;
    logic [39:0] enemy_i = '0;
    logic [39:0] ball_o;
    logic [3:0]  score_player_o;
    logic [3:0]  score_enemy_o;
    logic        point_o;

    always #5 clk = ~clk;

    ball_ctrl #(
        .X_POS_W(10), .Y_POS_W(10), .SCREEN_H_RES(H), .SCREEN_V_RES(V),
        .BALL_SIDE(B), .SCREEN_BORDER(BORDER), .PADDLE_HEIGHT(PH), .SPEED_W(5),
        .DEFLECT_SPEED_X(DX), .DEFLECT_SPEED_Y(DY), .SIDE_HIT_SPEED_Y(SY),
        .SERVE_DELAY(SD)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .frame_tick_i(frame_tick_i),
        .player_i(player_i), .enemy_i(enemy_i), .ball_o(ball_o),
        .score_player_o(score_player_o), .score_enemy_o(score_enemy_o),
        .point_o(point_o)
    );

    typedef struct {
        int x; int y; int r; int b; int sp; int se; int pt;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    // Model state
    int m_x, m_y, m_dx, m_dy, m_vy;   // m_dx 1 = right, m_dy 1 = up
    int m_phase;                      // 0 serve, 1 move, 2 scored
    int m_cnt, m_scorer, m_sp, m_se;
    int p_x, p_y, p_r, p_b, e_x, e_y, e_r, e_b;

    task automatic chk(input string nm, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_reset();
        m_x = CX; m_y = CY; m_dx = 0; m_dy = 0; m_vy = DY;
        m_phase = 0; m_cnt = 0; m_scorer = 0; m_sp = 0; m_se = 0;
    endtask

    // Ball bounce speed and direction from where it struck a paddle.
    task automatic zone(input int pad_y);
        int bc, pc;
        bc = m_y + B/2;
        pc = pad_y + PH/2;
        m_vy = (iabs(bc - pc) <= PH/4) ? DY : SY;
        m_dy = (bc < pc) ? 1 : 0;
    endtask

    task automatic model_move();
        int bl, br, bt, bb;
        bit hit_l, hit_r;
        bl = m_x; br = m_x + B - 1; bt = m_y; bb = m_y + B - 1;
        hit_l = (m_dx == 0) && (bl <= p_r + DX) && (br >= p_x) && (bb >= p_y) && (bt <= p_b);
        hit_r = (m_dx == 1) && (br + DX >= e_x) && (bl <= e_r) && (bb >= e_y) && (bt <= e_b);
        if (hit_l) begin
            zone(p_y); m_x = p_r + 1; m_dx = 1;
        end else if (hit_r) begin
            zone(e_y); m_x = e_x - B; m_dx = 0;
        end else if (m_dx == 0 && m_x < DX) begin
            m_phase = 2; m_scorer = 0;
        end else if (m_dx == 1 && m_x + B + DX > H) begin
            m_phase = 2; m_scorer = 1;
        end else begin
            m_x = m_x + ((m_dx == 1) ? DX : -DX);
        end
        if (m_dy == 1) begin
            if (m_y < BORDER + m_vy) begin m_y = BORDER; m_dy = 0; end
            else m_y = m_y - m_vy;
        end else begin
            if (m_y + B + m_vy > V - BORDER) begin m_y = V - BORDER - B; m_dy = 1; end
            else m_y = m_y + m_vy;
        end
    endtask

    task automatic model_edge(input bit tick, input bit rst);
        if (rst) begin
            model_reset();
        end else if (m_phase == 2) begin
            if (m_scorer == 1) begin
                if (m_sp < 15) m_sp++;
                m_dx = 1;
            end else begin
                if (m_se < 15) m_se++;
                m_dx = 0;
            end
            m_x = CX; m_y = CY; m_vy = DY; m_phase = 0;
            $display("point to %s: player=%0d enemy=%0d", (m_scorer == 1) ? "player" : "enemy", m_sp, m_se);
        end else if (tick) begin
            if (m_phase == 0) begin
                if (m_cnt == SD - 1) begin m_cnt = 0; m_phase = 1; end
                else m_cnt++;
            end else begin
                model_move();
            end
        end
    endtask

    task automatic step(input bit tick, input bit rst);
        exp_t e;
        bit was_scored;
        frame_tick_i = tick;
        rst_i        = rst;
        @(posedge clk);
        was_scored = (m_phase == 2);
        model_edge(tick, rst);
        if (tick || was_scored) begin
            e.x = m_x; e.y = m_y; e.r = m_x + B - 1; e.b = m_y + B - 1;
            e.sp = m_sp; e.se = m_se; e.pt = (m_phase == 2) ? 1 : 0;
            q.push_back(e);
        end
        #1;
        frame_tick_i = 1'b0;
        rst_i        = 1'b0;
    endtask

    function automatic int track_y();
        int v;
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(10, 430));
        v = m_y + int'($urandom_range(0, 70)) - 55;
        if (v < 10)  v = 10;
        if (v > 430) v = 430;
        return v;
    endfunction

    // mode 0: both paddles off the ball's rows; 1: player tracks, enemy off; 2: both track
    task automatic set_paddles(input int mode);
        p_x = int'($urandom_range(0, 10));  p_r = p_x + 9;
        e_x = int'($urandom_range(620, 630)); e_r = e_x + 9;
        if (mode >= 1) begin p_y = track_y(); p_b = p_y + PH - 1; end
        else begin p_y = 0; p_b = 0; end
        if (mode == 2) begin e_y = track_y(); e_b = e_y + PH - 1; end
        else begin e_y = 0; e_b = 0; end
        player_i = {10'(p_x), 10'(p_y), 10'(p_r), 10'(p_b)};
        enemy_i  = {10'(e_x), 10'(e_y), 10'(e_r), 10'(e_b)};
    endtask

    task automatic run_ticks(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            set_paddles(mode);
            step(1'b1, 1'b0);
            // Half the time, hit the single SCORED cycle with a tick that must be ignored.
            if (m_phase == 2 && $urandom_range(0, 1) == 1) step(1'b1, 1'b0);
            else repeat ($urandom_range(0, 2)) step(1'b0, 1'b0);
        end
    endtask

    // Monitor: compares after every tick and after every point pulse.
    initial begin : monitor
        bit   t;
        bit   pprev;
        exp_t e;
        pprev = 1'b0;
        forever begin
            @(posedge clk);
            t = frame_tick_i;
            @(negedge clk);
            if (t || pprev) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: point_o=%0d with no queued expectation at %0t", point_o, $time);
                end else begin
                    e = q.pop_front();
                    chk("ball_x",   int'(ball_o[39:30]), e.x);
                    chk("ball_y",   int'(ball_o[29:20]), e.y);
                    chk("ball_r",   int'(ball_o[19:10]), e.r);
                    chk("ball_b",   int'(ball_o[9:0]),   e.b);
                    chk("score_p",  int'(score_player_o), e.sp);
                    chk("score_e",  int'(score_enemy_o),  e.se);
                    chk("point",    int'(point_o),        e.pt);
                end
            end
            pprev = point_o;
        end
    end

    initial begin : stimulus
        model_reset();
        set_paddles(0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        @(negedge clk);
        chk("reset_x",  int'(ball_o[39:30]), 315);
        chk("reset_y",  int'(ball_o[29:20]), 235);
        chk("reset_r",  int'(ball_o[19:10]), 324);
        chk("reset_b",  int'(ball_o[9:0]),   244);
        chk("reset_sp", int'(score_player_o), 0);
        chk("reset_se", int'(score_enemy_o),  0);
        chk("reset_pt", int'(point_o), 0);

        // Serve: two ticks hold the ball, the third moves it left and down.
        step(1'b1, 1'b0); step(1'b0, 1'b0);
        @(negedge clk);
        chk("serve_hold_x", int'(ball_o[39:30]), 315);
        step(1'b1, 1'b0); step(1'b0, 1'b0);
        @(negedge clk);
        chk("serve_hold2_x", int'(ball_o[39:30]), 315);
        step(1'b1, 1'b0);
        @(negedge clk);
        chk("serve_move_x", int'(ball_o[39:30]), 311);
        chk("serve_move_y", int'(ball_o[29:20]), 236);
        $display("serve done: ball at x=%0d y=%0d", ball_o[39:30], ball_o[29:20]);

        // Enemy scores every rally: drives the enemy score into saturation.
        run_ticks(1700, 0);
        repeat (3) step(1'b0, 1'b0);
        @(negedge clk);
        chk("enemy_saturated", int'(score_enemy_o), 15);

        run_ticks(7000, 1);
        run_ticks(3000, 2);

        // Reset together with a tick: reset wins.
        set_paddles(2);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        @(negedge clk);
        chk("midreset_sp", int'(score_player_o), 0);
        chk("midreset_se", int'(score_enemy_o), 0);
        chk("midreset_x",  int'(ball_o[39:30]), 315);

        run_ticks(300, 2);
        repeat (5) step(1'b0, 1'b0);
        @(negedge clk);
        chk("queue_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ball_ctrl.md
# ball_ctrl

Frame-rate ball motion controller for the pong datapath. It reads the player and enemy paddle `sprite_t` records written by the paddle controllers, and once per frame tick advances the ball. On each tick it resolves wall and paddle collisions, detects misses, keeps score and re-serves. It publishes the ball as a registered `sprite_t`, which the renderer consumes alongside the paddle sprites.

## Interface
Parameters:
- `X_POS_W`, 10, x coordinate width
- `Y_POS_W`, 10, y coordinate width
- `SCREEN_H_RES`, 640, visible width
- `SCREEN_V_RES`, 480, visible height
- `BALL_SIDE`, 10, ball edge length in pixels
- `SCREEN_BORDER`, 10, top/bottom wall thickness
- `PADDLE_HEIGHT`, 50, paddle height, used for hit zoning
- `SPEED_W`, 5, speed field width; x magnitude is `SPEED_W-2` bits, y magnitude is `SPEED_W-1` bits
- `DEFLECT_SPEED_X`, 4, fixed x magnitude
- `DEFLECT_SPEED_Y`, 1, y magnitude after a centre hit
- `SIDE_HIT_SPEED_Y`, 5, y magnitude after an edge hit
- `SERVE_DELAY`, 60, frame ticks spent in SERVE

Ports:
- `clk_i`  in  1  system clock
- `rst_i`  in  1  synchronous, active-high reset
- `frame_tick_i`  in  1  one-cycle pulse per frame; the only update strobe
- `player_i`  in  `sprite_t`  left paddle (`x_pos`, `y_pos`, `right`, `bottom`)
- `enemy_i`  in  `sprite_t`  right paddle
- `ball_o`  out  `sprite_t`  registered ball record
- `score_player_o`  out  4  player points, saturating at 15
- `score_enemy_o`  out  4  enemy points, saturating at 15
- `point_o`  out  1  one-cycle pulse when a point is scored

## Operation
- Internal state: `x`, `y`, `dir_x` (0 = left), `dir_y` (0 = down), `vy` magnitude. The x speed is always `DEFLECT_SPEED_X`.
- `ball_o.right` = x + BALL_SIDE − 1 and `ball_o.bottom` = y + BALL_SIDE − 1. Both are registered together with x/y, never combinational.
- **Centre position:** x = SCREEN_H_RES/2 − BALL_SIDE/2, y = SCREEN_V_RES/2 − BALL_SIDE/2.
- **FSM states:** SERVE, MOVE, SCORED. All transitions except SCORED→SERVE occur only on `frame_tick_i`.
- **SERVE:**
  - Ball is held at the centre position.
  - A serve counter increments per tick.
  - On the tick where the counter == SERVE_DELAY−1, clear the counter and go to MOVE. The ball does not move on that tick.
- **MOVE, x axis (per tick):**
  - Left paddle hit: `dir_x`=0, x ≤ player.right + DEFLECT_SPEED_X, ball.right ≥ player.x_pos, ball.bottom ≥ player.y_pos, y ≤ player.bottom.
  - On a left hit: x := player.right + 1, `dir_x` := 1.
  - Right paddle hit: the mirror condition against enemy; on a hit x := enemy.x_pos − BALL_SIDE, `dir_x` := 0.
  - Miss left: no left hit and x < DEFLECT_SPEED_X. Enemy scores; go to SCORED.
  - Miss right: no right hit and x + BALL_SIDE + DEFLECT_SPEED_X > SCREEN_H_RES. Player scores; go to SCORED.
  - Otherwise x moves by ±DEFLECT_SPEED_X.
  - Paddle hit takes priority over miss.
- **Hit zoning (on any paddle hit):**
  - Ball centre is y + BALL_SIDE/2; paddle centre is paddle.y_pos + PADDLE_HEIGHT/2.
  - |ball centre − paddle centre| ≤ PADDLE_HEIGHT/4: `vy` := DEFLECT_SPEED_Y.
  - Otherwise `vy` := SIDE_HIT_SPEED_Y.
  - `dir_y` := up when ball centre < paddle centre, else down.
- **MOVE, y axis (per tick, evaluated independently of x):**
  - Moving up and y < SCREEN_BORDER + vy: y := SCREEN_BORDER, `dir_y` := down.
  - Moving down and y + BALL_SIDE + vy > SCREEN_V_RES − SCREEN_BORDER: y := SCREEN_V_RES − SCREEN_BORDER − BALL_SIDE, `dir_y` := up.
  - Otherwise y moves by ±vy.
  - A paddle hit and a wall bounce on the same tick both apply. Zoning sets `vy`/`dir_y` first; the wall clamp then uses the new values.
- **SCORED (one clock):**
  - Increment the scorer's counter, saturating at 15.
  - Assert `point_o`.
  - Reset ball to the centre position, `vy` := DEFLECT_SPEED_Y, `dir_x` := toward the losing side.
  - Go to SERVE.
- All arithmetic uses unsigned compares widened by one bit to avoid wrap. x and y never leave [0, RES − BALL_SIDE].

## Timing
- `ball_o` and the scores update on the clock edge that samples `frame_tick_i`; they are visible 1 cycle after the tick.
- `point_o` is high for exactly the cycle following the missing tick, i.e. while the FSM is in SCORED.
- A tick arriving while in SCORED is ignored.
- Reset values:
  - `ball_o` = {315, 235, 324, 244} at default parameters.
  - Scores 0, `point_o` 0.
  - State SERVE, counter 0, `dir_x` left, `dir_y` down, `vy` = 1.
- Reset asserted mid-operation overrides the tick in the same cycle.

## Test plan
- **Reset:** assert `rst_i` 2 cycles → `ball_o` = {315, 235, 324, 244}, scores 0, `point_o` 0.
- **Serve:** SERVE_DELAY=2, three ticks → ball static through tick 2; after tick 3, x = 311, y = 236.
- **Top wall:** y = 12, `dir_y` up, `vy` = 5, one tick → y = 10, `dir_y` down.
- **Centre hit:** player {0, 200, 9, 249}, ball at x = 12, y = 220 moving left, one tick → x = 10, `dir_x` right, `vy` = 1, `dir_y` down.
- **Edge hit:** same player, ball y = 196, one tick → `vy` = 5, `dir_y` up.
- **Miss and saturation:** player paddle out of the way, ball at x = 3 moving left → `point_o` for 1 cycle, enemy score 1, ball at centre. Repeat from enemy score 15 → score stays 15.
